// File: rtl/reg_stat_gen.sv
// Packed status register with per-field access modes (RW, W1C, CNT, RO) and a CPU write handshake.
// Optional W1C interrupt output is enabled by defining REG_STAT_GEN_INTR_EN.
module reg_stat_gen #(
    parameter int                    BITDATA = 22,
    parameter int                    NUMFLD  = 4,
    parameter int                    BITFLD  = 4,
    parameter logic [NUMFLD*5-1:0]   FLDOFST = {5'd16, 5'd4, 5'd2, 5'd0},
    parameter logic [NUMFLD*5-1:0]   FLDWID  = {5'd4, 5'd1, 5'd1, 5'd1},
    parameter logic [NUMFLD*2-1:0]   FLDMODE = {2'd2, 2'd1, 2'd0, 2'd0},
    parameter logic [BITDATA-1:0]    PORVAL  = '0,
    parameter bit                    FLOPODT = 1'b0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cwrite,
    input  logic [BITDATA-1:0]       cdin,
    output logic                     cwack,
    output logic [BITDATA-1:0]       cdout,
    input  logic [NUMFLD-1:0]        fld_wr,
    input  logic [NUMFLD*BITFLD-1:0] fld_din,
    input  logic [NUMFLD-1:0]        fld_inc,
    output logic [NUMFLD*BITFLD-1:0] fld_rdat
`ifdef REG_STAT_GEN_INTR_EN
    ,
    output logic                     cintr
`endif
);

    localparam logic [1:0] MODE_RW  = 2'd0;
    localparam logic [1:0] MODE_W1C = 2'd1;
    localparam logic [1:0] MODE_CNT = 2'd2;

    function automatic bit layout_ok();
        logic [BITDATA-1:0] used;
        int                 off;
        int                 wid;
        bit                 ok;
        used = '0;
        ok   = 1'b1;
        for (int i = 0; i < NUMFLD; i++) begin
            off = int'(FLDOFST[i*5 +: 5]);
            wid = int'(FLDWID[i*5 +: 5]);
            if (wid < 1 || wid > BITFLD || off + wid > BITDATA) ok = 1'b0;
            for (int b = 0; b < BITFLD; b++) begin
                if (b < wid && off + b < BITDATA) begin
                    if (used[off+b]) ok = 1'b0;
                    used[off+b] = 1'b1;
                end
            end
        end
        return ok;
    endfunction

    localparam bit LAYOUT_OK = layout_ok();

    generate
        if (!LAYOUT_OK) begin : g_bad_layout
            $error("reg_stat_gen: fields overlap or extend beyond BITDATA");
        end
    endgenerate

    typedef enum logic [1:0] {S_IDLE, S_ACK, S_HOLD} state_t;

    state_t state_q, state_d;
    logic   cpu_wr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= S_IDLE;
        else      state_q <= state_d;
    end

    // The CPU write lands only on the IDLE->ACK edge, so a held cwrite is applied once.
    always_comb begin
        state_d = state_q;
        cpu_wr  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (cwrite) begin
                    cpu_wr  = 1'b1;
                    state_d = S_ACK;
                end
            end
            S_ACK:   state_d = S_HOLD;
            S_HOLD:  if (!cwrite) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign cwack = (state_q == S_ACK);

    logic [NUMFLD*BITDATA-1:0] rd_parts;
    logic [BITDATA-1:0]        rd_word;
`ifdef REG_STAT_GEN_INTR_EN
    logic [NUMFLD-1:0]         w1c_bits;
`endif

    generate
        for (genvar gi = 0; gi < NUMFLD; gi++) begin : g_fld
            localparam int              OFF  = int'(FLDOFST[gi*5 +: 5]);
            localparam int              WID  = int'(FLDWID[gi*5 +: 5]);
            localparam logic [1:0]      MODE = FLDMODE[gi*2 +: 2];
            localparam logic [BITFLD-1:0] MASK = BITFLD'((1 << WID) - 1);
            localparam logic [BITFLD-1:0] RSTV = BITFLD'(PORVAL >> OFF) & MASK;

            logic [BITFLD-1:0] val_q, val_d;
            logic [BITFLD-1:0] cpu_s, fn_s;

            assign cpu_s = BITFLD'(cdin >> OFF) & MASK;
            assign fn_s  = fld_din[gi*BITFLD +: BITFLD] & MASK;

            // Functional write beats increment, which beats the CPU write.
            always_comb begin
                val_d = val_q;
                if (fld_wr[gi]) begin
                    val_d = (MODE == MODE_W1C) ? (val_q | fn_s) : fn_s;
                end else if (fld_inc[gi] && MODE == MODE_CNT) begin
                    if (val_q != MASK) val_d = val_q + BITFLD'(1);
                end else if (cpu_wr) begin
                    case (MODE)
                        MODE_RW, MODE_CNT: val_d = cpu_s;
                        MODE_W1C:          val_d = val_q & ~cpu_s;
                        default:           val_d = val_q;
                    endcase
                end
            end

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) val_q <= RSTV;
                else      val_q <= val_d;
            end

            assign fld_rdat[gi*BITFLD +: BITFLD]  = val_q;
            assign rd_parts[gi*BITDATA +: BITDATA] = BITDATA'(val_q) << OFF;
`ifdef REG_STAT_GEN_INTR_EN
            assign w1c_bits[gi] = (MODE == MODE_W1C) ? (|val_q) : 1'b0;
`endif
        end
    endgenerate

    always_comb begin
        rd_word = '0;
        for (int i = 0; i < NUMFLD; i++) begin
            rd_word = rd_word | rd_parts[i*BITDATA +: BITDATA];
        end
    end

    generate
        if (FLOPODT) begin : g_cdout_flop
            logic [BITDATA-1:0] cdout_q;
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) cdout_q <= '0;
                else      cdout_q <= rd_word;
            end
            assign cdout = cdout_q;
        end else begin : g_cdout_comb
            assign cdout = rd_word;
        end
    endgenerate

`ifdef REG_STAT_GEN_INTR_EN
    logic cintr_q;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cintr_q <= 1'b0;
        else      cintr_q <= |w1c_bits;
    end
    assign cintr = cintr_q;
`endif

endmodule
